// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: fetch FSM states,
// primary opcode constants and the default reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mips_pcnext.sv
// Next-PC selection: sequential, branch and jump targets with
// jump > branch > sequential priority. Purely combinational.
module mips_pcnext (
    input  logic [31:0] pc,
    input  logic [25:0] instr_index,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] pcplus4,
    output logic [31:0] pcnext
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign pcplus4       = pc + 32'd4;
    assign branch_target = pcplus4 + {{14{instr_index[15]}}, instr_index[15:0], 2'b00};
    assign jump_target   = {pcplus4[31:28], instr_index, 2'b00};

    always_comb begin
        // NOTE: the default-first assignment keeps this block latch-free
        pcnext = pcplus4;
        if (jump)
            pcnext = jump_target;
        else if (pcsrc)
            pcnext = branch_target;
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: owns PC, instruction register and retired
// count, fetching from imem over a req/ready handshake.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic [31:0]      pc,
    output logic [31:0]      pcplus4,
    input  logic             advance,
    input  logic             pcsrc,
    input  logic             jump,
    output logic [CNT_W-1:0] icount
);

    fetch_state_t state;
    logic [31:0]  pcnext;

    mips_pcnext u_pcnext (
        .pc          (pc),
        .instr_index (instr[25:0]),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .pcplus4     (pcplus4),
        .pcnext      (pcnext)
    );

    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];

    // imem_req is registered and toggled on state transitions so it tracks FETCH exactly.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            icount      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        pc          <= pcnext;
                        instr_valid <= 1'b0;
                        icount      <= icount + CNT_W'(1);
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios plus a
// randomized run checked against a behavioural next-PC model.
module tb_mips_fetch_unit;
    import mips_pkg::*;

    logic        clk;
    logic        reset, imem_ready, advance, pcsrc, jump;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pcplus4, icount;
    logic [5:0]  op, funct;

    logic        reset_b, imem_ready_b, advance_b, pcsrc_b, jump_b;
    logic [31:0] imem_rdata_b;
    logic        imem_req_b, instr_valid_b;
    logic [31:0] imem_addr_b, instr_b, pc_b, pcplus4_b;
    logic [5:0]  op_b, funct_b;
    logic [3:0]  icount_b;

    int n_tests = 0;
    int n_fail  = 0;

    mips_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .op(op), .funct(funct), .pc(pc), .pcplus4(pcplus4),
        .advance(advance), .pcsrc(pcsrc), .jump(jump), .icount(icount)
    );

    mips_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut_wrap (
        .clk(clk), .reset(reset_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_ready(imem_ready_b), .imem_rdata(imem_rdata_b), .instr_valid(instr_valid_b),
        .instr(instr_b), .op(op_b), .funct(funct_b), .pc(pc_b), .pcplus4(pcplus4_b),
        .advance(advance_b), .pcsrc(pcsrc_b), .jump(jump_b), .icount(icount_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural next-PC: jump beats branch beats sequential.
    function automatic logic [31:0] ref_next_pc(input logic [31:0] p, input logic [31:0] w,
                                                input logic j, input logic b);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        off = int'($signed(w[15:0]));
        if (j)
            return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        else if (b)
            return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic apply_reset();
        reset = 1'b1; imem_ready = 1'b0; advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic fetch_and_retire(input logic [31:0] w, input logic j, input logic b);
        imem_ready = 1'b1; imem_rdata = w;
        step();
        imem_ready = 1'b0;
        advance = 1'b1; jump = j; pcsrc = b;
        step();
        advance = 1'b0; jump = 1'b0; pcsrc = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] w;
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        step();
        n_tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || icount !== 32'h0 || instr !== 32'h0) begin
            $display("FAIL reset_state: req=%b valid=%b pc=%h icount=%0d instr=%h, expected 0,0,0,0,0",
                     imem_req, instr_valid, pc, icount, instr);
            n_fail++;
        end
        reset = 1'b0;
        w = {OP_LW, 26'h1A2_B3C5};
        imem_rdata = w;
        step();
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            $display("FAIL reset_first_req: req=%b addr=%h valid=%b, expected 1,00000000,0",
                     imem_req, imem_addr, instr_valid);
            n_fail++;
        end
        step();
        n_tests++;
        if (instr_valid !== 1'b1 || instr !== w || op !== OP_LW || funct !== w[5:0] || imem_req !== 1'b0) begin
            $display("FAIL reset_first_instr: valid=%b instr=%h op=%h funct=%h req=%b, expected 1,%h,%h,%h,0",
                     instr_valid, instr, op, funct, imem_req, w, OP_LW, w[5:0]);
            n_fail++;
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        logic [31:0] w;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                $display("FAIL wait_cycle%0d: req=%b addr=%h valid=%b, expected 1,00000000,0",
                         i, imem_req, imem_addr, instr_valid);
                n_fail++;
            end
            step();
        end
        w = $urandom;
        imem_ready = 1'b1; imem_rdata = w;
        step();
        imem_ready = 1'b0;
        n_tests++;
        if (instr_valid !== 1'b1 || instr !== w) begin
            $display("FAIL wait_ready: valid=%b instr=%h, expected 1,%h", instr_valid, instr, w);
            n_fail++;
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        apply_reset();
        exp_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (imem_addr !== exp_addr || imem_req !== 1'b1) begin
                $display("FAIL seq_addr%0d: addr=%h req=%b, expected %h,1", i, imem_addr, imem_req, exp_addr);
                n_fail++;
            end
            fetch_and_retire($urandom, 1'b0, 1'b0);
            exp_addr = exp_addr + 32'd4;
        end
        n_tests++;
        if (icount !== 32'd4 || imem_addr !== 32'h10) begin
            $display("FAIL seq_count: icount=%0d addr=%h, expected 4,00000010", icount, imem_addr);
            n_fail++;
        end
    endtask

    task automatic test_branch();
        apply_reset();
        fetch_and_retire(32'h0800_0004, 1'b1, 1'b0);
        n_tests++;
        if (imem_addr !== 32'h10) begin
            $display("FAIL br_setup_jump: addr=%h, expected 00000010", imem_addr);
            n_fail++;
        end
        fetch_and_retire(32'h1000_FFFF, 1'b0, 1'b1);
        n_tests++;
        if (imem_addr !== 32'h10) begin
            $display("FAIL br_backward: addr=%h, expected 00000010", imem_addr);
            n_fail++;
        end
        fetch_and_retire(32'h0800_0040, 1'b1, 1'b0);
        n_tests++;
        if (imem_addr !== 32'h100) begin
            $display("FAIL br_jump: addr=%h, expected 00000100", imem_addr);
            n_fail++;
        end
        fetch_and_retire(32'h1000_0003, 1'b1, 1'b1);
        n_tests++;
        if (imem_addr !== 32'h0000_000C) begin
            $display("FAIL br_jump_priority: addr=%h, expected 0000000c", imem_addr);
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic [31:0] m_pc, m_cnt, w;
        logic        pj, pb;
        int          waits, holds;
        apply_reset();
        m_pc = 32'h0; m_cnt = 32'h0;
        for (int k = 0; k < 40; k++) begin
            waits = $urandom_range(0, 2);
            for (int i = 0; i < waits; i++) begin
                imem_ready = 1'b0;
                advance = 1'($urandom); pcsrc = 1'($urandom); jump = 1'($urandom);
                step();
                n_tests++;
                if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0 || icount !== m_cnt) begin
                    $display("FAIL rnd_wait k=%0d: req=%b addr=%h valid=%b icount=%0d, expected 1,%h,0,%0d",
                             k, imem_req, imem_addr, instr_valid, icount, m_pc, m_cnt);
                    n_fail++;
                end
            end
            w = $urandom;
            imem_ready = 1'b1; imem_rdata = w; advance = 1'($urandom);
            step();
            imem_ready = 1'b0; imem_rdata = $urandom; advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
            n_tests++;
            if (instr_valid !== 1'b1 || instr !== w || op !== w[31:26] || funct !== w[5:0] ||
                pc !== m_pc || pcplus4 !== m_pc + 32'd4 || imem_req !== 1'b0) begin
                $display("FAIL rnd_fetch k=%0d: valid=%b instr=%h pc=%h pcplus4=%h req=%b, expected 1,%h,%h,%h,0",
                         k, instr_valid, instr, pc, pcplus4, imem_req, w, m_pc, m_pc + 32'd4);
                n_fail++;
            end
            holds = $urandom_range(0, 2);
            for (int i = 0; i < holds; i++) begin
                imem_ready = 1'($urandom); pcsrc = 1'($urandom); jump = 1'($urandom);
                step();
                n_tests++;
                if (instr_valid !== 1'b1 || instr !== w || imem_req !== 1'b0 || pc !== m_pc) begin
                    $display("FAIL rnd_hold k=%0d: valid=%b instr=%h req=%b pc=%h, expected 1,%h,0,%h",
                             k, instr_valid, instr, imem_req, pc, w, m_pc);
                    n_fail++;
                end
            end
            pj = 1'($urandom); pb = 1'($urandom);
            imem_ready = 1'b0; advance = 1'b1; jump = pj; pcsrc = pb;
            step();
            advance = 1'b0; jump = 1'b0; pcsrc = 1'b0;
            m_pc = ref_next_pc(m_pc, w, pj, pb);
            m_cnt = m_cnt + 32'd1;
            n_tests++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0 || icount !== m_cnt) begin
                $display("FAIL rnd_advance k=%0d j=%b b=%b: req=%b addr=%h valid=%b icount=%0d, expected 1,%h,0,%0d",
                         k, pj, pb, imem_req, imem_addr, instr_valid, icount, m_pc, m_cnt);
                n_fail++;
            end
        end
    endtask

    task automatic test_wrap();
        imem_ready_b = 1'b1; imem_rdata_b = 32'h0; advance_b = 1'b0; pcsrc_b = 1'b0; jump_b = 1'b0;
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        step();
        n_tests++;
        if (imem_addr_b !== 32'hFFFF_FFFC || pcplus4_b !== 32'h0 || imem_req_b !== 1'b1) begin
            $display("FAIL wrap_start: addr=%h pcplus4=%h req=%b, expected fffffffc,00000000,1",
                     imem_addr_b, pcplus4_b, imem_req_b);
            n_fail++;
        end
        for (int i = 1; i <= 16; i++) begin
            step();
            advance_b = 1'b1;
            step();
            advance_b = 1'b0;
            if (i == 1) begin
                n_tests++;
                if (imem_addr_b !== 32'h0 || icount_b !== 4'd1) begin
                    $display("FAIL wrap_pc: addr=%h icount=%0d, expected 00000000,1", imem_addr_b, icount_b);
                    n_fail++;
                end
            end
            if (i == 15) begin
                n_tests++;
                if (icount_b !== 4'd15) begin
                    $display("FAIL wrap_cnt15: icount=%0d, expected 15", icount_b);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (icount_b !== 4'd0) begin
            $display("FAIL wrap_cnt0: icount=%0d, expected 0", icount_b);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        fetch_and_retire($urandom, 1'b0, 1'b0);
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D; advance = 1'b1;
        step();
        advance = 1'b0;
        n_tests++;
        if (pc !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0 || icount !== 32'h0) begin
            $display("FAIL rst_mid_fetch: pc=%h valid=%b req=%b instr=%h icount=%0d, expected 0,0,0,0,0",
                     pc, instr_valid, imem_req, instr, icount);
            n_fail++;
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            $display("FAIL rst_release: valid=%b req=%b addr=%h, expected 0,1,00000000",
                     instr_valid, imem_req, imem_addr);
            n_fail++;
        end
        imem_ready = 1'b0; advance = 1'b1; pcsrc = 1'b1; jump = 1'b1;
        step();
        advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        n_tests++;
        if (pc !== 32'h0 || icount !== 32'h0 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            $display("FAIL advance_ignored: pc=%h icount=%0d req=%b valid=%b, expected 0,0,1,0",
                     pc, icount, imem_req, instr_valid);
            n_fail++;
        end
        fetch_and_retire($urandom, 1'b0, 1'b0);
        imem_ready = 1'b1; imem_rdata = $urandom;
        step();
        imem_ready = 1'b0;
        reset = 1'b1; advance = 1'b1;
        step();
        reset = 1'b0; advance = 1'b0;
        n_tests++;
        if (pc !== 32'h0 || icount !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0) begin
            $display("FAIL rst_mid_hold: pc=%h icount=%0d valid=%b instr=%h req=%b, expected 0,0,0,0,0",
                     pc, icount, instr_valid, instr, imem_req);
            n_fail++;
        end
    endtask

    initial begin
        reset_b = 1'b1; imem_ready_b = 1'b0; imem_rdata_b = 32'h0;
        advance_b = 1'b0; pcsrc_b = 1'b0; jump_b = 1'b0;
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
        advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        test_reset();
        test_wait_states();
        test_sequential();
        test_branch();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
